// File: rtl/rr_bus_arbiter16.sv
// rtl/rr_bus_arbiter16.sv - round-robin arbiter sharing a 32-bit result bus among 16 requesters

// Two-input mux leaf used to build the wider select trees.
module mux2x1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] dout
);

  assign dout = sel ? in1 : in0;

endmodule

// Four-input mux: two leaves on sel[0], one leaf on sel[1].
module mux4x1 #(
  parameter int W = 32
) (
  input  logic [4*W-1:0] din,
  input  logic [1:0]     sel,
  output logic [W-1:0]   dout
);

  logic [W-1:0] lo;
  logic [W-1:0] hi;

  mux2x1 #(.W(W)) u_lo  (.in0(din[0*W +: W]), .in1(din[1*W +: W]), .sel(sel[0]), .dout(lo));
  mux2x1 #(.W(W)) u_hi  (.in0(din[2*W +: W]), .in1(din[3*W +: W]), .sel(sel[0]), .dout(hi));
  mux2x1 #(.W(W)) u_top (.in0(lo),            .in1(hi),            .sel(sel[1]), .dout(dout));

endmodule

// Eight-input mux: two 4x1 halves joined by a 2x1 on sel[2].
module mux8x1 #(
  parameter int W = 32
) (
  input  logic [8*W-1:0] din,
  input  logic [2:0]     sel,
  output logic [W-1:0]   dout
);

  logic [W-1:0] lo;
  logic [W-1:0] hi;

  mux4x1 #(.W(W)) u_lo  (.din(din[0*W +: 4*W]), .sel(sel[1:0]), .dout(lo));
  mux4x1 #(.W(W)) u_hi  (.din(din[4*W +: 4*W]), .sel(sel[1:0]), .dout(hi));
  mux2x1 #(.W(W)) u_top (.in0(lo), .in1(hi), .sel(sel[2]), .dout(dout));

endmodule

// Sixteen-input mux: two 8x1 halves joined by a 2x1 on sel[3].
module mux16x1 #(
  parameter int W = 32
) (
  input  logic [16*W-1:0] din,
  input  logic [3:0]      sel,
  output logic [W-1:0]    dout
);

  logic [W-1:0] lo;
  logic [W-1:0] hi;

  mux8x1 #(.W(W)) u_lo  (.din(din[0*W +: 8*W]), .sel(sel[2:0]), .dout(lo));
  mux8x1 #(.W(W)) u_hi  (.din(din[8*W +: 8*W]), .sel(sel[2:0]), .dout(hi));
  mux2x1 #(.W(W)) u_top (.in0(lo), .in1(hi), .sel(sel[3]), .dout(dout));

endmodule

// Arbiter top: one grant at a time, one idle bubble between grants, and a
// hold limit so a streaming requester cannot monopolise the bus.
module rr_bus_arbiter16 #(
  parameter int MAX_HOLD = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [15:0]  REQ,
  input  logic [511:0] DATA_IN,
  output logic [15:0]  GNT,
  output logic [3:0]   SEL,
  output logic [31:0]  DOUT,
  output logic         DOUT_VALID,
  input  logic         DOUT_READY,
  output logic         BUSY
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // hold_cnt counts completed transfers, so the last allowed one sees MAX_HOLD-1
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] gnt_q;
  logic [15:0] gnt_d;
  logic [3:0]  sel_q;
  logic [3:0]  sel_d;
  logic [3:0]  ptr_q;
  logic [3:0]  ptr_d;
  logic [7:0]  hold_cnt_q;
  logic [7:0]  hold_cnt_d;

  logic        win_found;
  logic [3:0]  win_idx;
  logic        holder_req;
  logic        busy;
  logic        valid;
  logic        xfer;
  logic        rel_now;
  logic [31:0] mux_out;

  // Data path: SEL steers the mux tree; output is forced to zero when not valid.
  mux16x1 #(.W(32)) u_mux (
    .din  (DATA_IN),
    .sel  (sel_q),
    .dout (mux_out)
  );

  assign holder_req = REQ[sel_q];
  assign busy       = (state_q == GRANT);
  assign valid      = busy & holder_req;
  assign xfer       = valid & DOUT_READY;
  // Release when the holder drops its request or its last allowed transfer completes.
  assign rel_now    = busy & (~holder_req | (xfer & (hold_cnt_q == HOLD_LAST)));

  assign GNT        = gnt_q;
  assign SEL        = sel_q;
  assign BUSY       = busy;
  assign DOUT_VALID = valid;
  assign DOUT       = valid ? mux_out : 32'h0;

  // Rotating priority search: first requester at or after ptr, wrapping mod 16.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 0; i < 16; i++) begin
      if (!win_found && REQ[ptr_q + 4'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 4'(i);
      end
    end
  end

  // Next-state logic: grant in IDLE, count transfers and release in GRANT.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          gnt_d      = 16'h1 << win_idx;
          sel_d      = win_idx;
          hold_cnt_d = 8'h0;
        end else begin
          gnt_d = 16'h0;
        end
      end
      GRANT: begin
        if (rel_now) begin
          // SEL keeps the last holder; the pointer moves just past it.
          state_d    = IDLE;
          gnt_d      = 16'h0;
          ptr_d      = sel_q + 4'd1;
          hold_cnt_d = 8'h0;
        end else if (xfer) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 16'h0;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      gnt_q      <= 16'h0;
      sel_q      <= 4'h0;
      ptr_q      <= 4'h0;
      hold_cnt_q <= 8'h0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: doc/rr_bus_arbiter16.md
Name: rr_bus_arbiter16

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit result bus among 16 requesters.
- Drives the 4-bit select of an internal 32-bit 16-to-1 mux tree, built from the existing 2x1/4x1/8x1/16x1 mux modules.
- Provides a valid/ready handshake to a single consumer.
- Sits between producer units, such as register-file read ports and ALU/shifter results, and a shared writeback/result bus.

Parameters:
- MAX_HOLD, default 8: maximum accepted transfers per grant before forced release; legal range 1..255.

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  asynchronous reset, active-high
- REQ  input  16  request per requester; bit k = requester k
- DATA_IN  input  512  requester data, flattened; requester k occupies bits [32k+31:32k]
- GNT  output  16  one-hot grant, registered
- SEL  output  4  index of current grant holder, registered; also drives the mux select
- DOUT  output  32  selected data; 0 when DOUT_VALID=0
- DOUT_VALID  output  1  data on DOUT is valid this cycle
- DOUT_READY  input  1  consumer accepts DOUT this cycle
- BUSY  output  1  a grant is active (state GRANT)

Behaviour:
- Reset (RST=1, asynchronous, any time including mid-transfer):
  - state=IDLE, GNT=0, SEL=0, ptr=0, hold_cnt=0, BUSY=0, DOUT_VALID=0, DOUT=0.
  - Removal of reset takes effect on the next CLK edge. No transfer is counted in the cycle reset is asserted.
- Internal state: 2-state FSM {IDLE, GRANT}; 4-bit priority pointer ptr; 8-bit hold_cnt.
- IDLE:
  - If REQ==0, stay in IDLE, GNT=0.
  - Otherwise, at the clock edge, the winner w is the first k with REQ[k]=1, scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - Next state GRANT; GNT<=one-hot(w), SEL<=w, hold_cnt<=0.
  - Latency: REQ assertion in cycle n gives GNT visible in cycle n+1.
- GRANT:
  - DOUT_VALID = REQ[SEL] (combinational).
  - DOUT = DATA_IN slice SEL via the mux tree, gated to 0 when DOUT_VALID=0.
  - A transfer occurs on a cycle with DOUT_VALID=1 and DOUT_READY=1; hold_cnt increments by 1 per transfer.
  - Release condition, evaluated at the clock edge, either of:
    - REQ[SEL]=0;
    - a transfer occurs with hold_cnt==MAX_HOLD-1.
  - On release: state<=IDLE, GNT<=0, ptr<=SEL+1 (4-bit wrap; 15 wraps to 0), hold_cnt<=0. SEL holds its last value.
  - No release: stay in GRANT, GNT and SEL unchanged.
- Bubble: exactly one IDLE cycle between consecutive grants (DOUT_VALID=0, BUSY=0). Arbitration happens in that IDLE cycle.
- Simultaneous events:
  - REQ[SEL] dropping in the same cycle as DOUT_READY=1: no transfer (DOUT_VALID=0); release.
  - Other REQ bits changing during GRANT have no effect until the next IDLE.
- Handshake rules:
  - The consumer may hold DOUT_READY low indefinitely. The grant holder stalls, hold_cnt is unchanged, and there is no timeout.
  - A requester must keep REQ[k] high to keep its data valid. Deasserting before any transfer yields zero transfers and frees the bus.
- Fairness: a requester with REQ continuously high is granted within 15 grant periods.

Test Plan:
- Reset mid-GRANT: requester 3 granted, 2 transfers done, assert RST -> GNT=0, DOUT_VALID=0, BUSY=0 immediately (no clock edge); after release, REQ=16'h0008 gives GNT=16'h0008 one cycle later, with ptr=0 restart.
- Single requester: REQ=16'h0020, DATA_IN[191:160]=32'hDEADBEEF, DOUT_READY=1 -> GNT=16'h0020 and SEL=5 at cycle n+1; DOUT=32'hDEADBEEF with DOUT_VALID=1 for 8 cycles (MAX_HOLD=8); then 1 IDLE cycle; then regrant to 5.
- Round-robin order: REQ=16'h8101 held, DOUT_READY=1 -> grant sequence 0, 8, 15, 0, each of 8 transfers, with one bubble cycle between grants.
- Wrap-around: ptr at 15 after a grant to 14, REQ=16'h4001 -> requester 0 wins over 14; after 0 releases, 14 wins.
- Backpressure: requester 2 granted, DOUT_READY low 20 cycles -> DOUT_VALID=1 and GNT=16'h0004 stable, hold_cnt unchanged; then READY high -> exactly 8 transfers counted before release.
- Early drop: requester 7 granted, REQ[7] falls together with DOUT_READY=1 after 3 transfers -> no 4th transfer, GNT=0 next cycle, ptr=8.
